// File: rtl/monitor_sumador4.sv
// monitor_sumador4: cycle-accurate reference model and result checker for the
// 4-bit adder (hold / add / subtract / clear). It mirrors the adder's Q into
// EXP and flags every cycle in which the adder's Q disagrees with the model.
// The checker state (IDLE / TRACK / FAULT) is held in one register and is
// decoded directly onto VALID and ERR_STICKY.
module monitor_sumador4 #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENB,
    input  logic             RCI,
    input  logic [1:0]       MODO,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [3:0]       Q_DUT,
    input  logic             CLR_STATS,
    output logic [3:0]       EXP,
    output logic             VALID,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next value of the adder's Q for one enabled edge; all arithmetic wraps mod 16.
    function automatic logic [3:0] model_next(
        input logic [1:0] modo,
        input logic       rci,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] cur
    );
        logic [3:0] res;
        case (modo)
            2'b00:   res = cur;
            2'b01:   res = a + b + {3'b000, rci};
            2'b10:   res = a - b;
            2'b11:   res = 4'h0;
            default: res = cur;
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [3:0]       exp_r;
    logic             err_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [CNT_W-1:0] chk_cnt_r;
    logic             valid_s;
    logic             sticky_s;
    logic             mism_s;
    logic             start_s;

    // Checker state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave IDLE on the first real operation, clear wins over a new mismatch.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRACK: begin
                if (mism_s && !CLR_STATS) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    state_nxt_s = ST_TRACK;
                end
            end
            ST_FAULT: begin
                if (CLR_STATS) begin
                    state_nxt_s = ST_TRACK;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State decode onto the status outputs (taken straight from the state register).
    always_comb begin
        valid_s  = 1'b0;
        sticky_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                valid_s  = 1'b0;
                sticky_s = 1'b0;
            end
            ST_TRACK: begin
                valid_s  = 1'b1;
                sticky_s = 1'b0;
            end
            ST_FAULT: begin
                valid_s  = 1'b1;
                sticky_s = 1'b1;
            end
            default: begin
                valid_s  = 1'b0;
                sticky_s = 1'b0;
            end
        endcase
    end

    // Compare Q against the pre-edge model value whenever the model is trusted.
    always_comb begin
        start_s = 1'b0;
        mism_s  = 1'b0;
        if (ENB && (MODO != 2'b00)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if (valid_s && (Q_DUT != exp_r)) begin
            mism_s = 1'b1;
        end else begin
            mism_s = 1'b0;
        end
    end

    // Reference model of the adder's Q; holds when the adder is disabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_r <= 4'h0;
        end else if (ENB) begin
            exp_r <= model_next(MODO, RCI, A, B, exp_r);
        end else begin
            exp_r <= exp_r;
        end
    end

    // One-cycle mismatch pulse; reflects the compare even on a clearing edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_r <= 1'b0;
        end else begin
            err_r <= mism_s;
        end
    end

    // Saturating compare and mismatch counters, cleared by CLR_STATS.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            chk_cnt_r <= '0;
            err_cnt_r <= '0;
        end else if (CLR_STATS) begin
            chk_cnt_r <= '0;
            err_cnt_r <= '0;
        end else begin
            if (valid_s && (chk_cnt_r != CNT_MAX)) begin
                chk_cnt_r <= chk_cnt_r + CNT_ONE;
            end else begin
                chk_cnt_r <= chk_cnt_r;
            end
            if (mism_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign EXP        = exp_r;
    assign VALID      = valid_s;
    assign ERR        = err_r;
    assign ERR_STICKY = sticky_s;
    assign ERR_CNT    = err_cnt_r;
    assign CHK_CNT    = chk_cnt_r;

endmodule

// File: tb/tb_monitor_sumador4.sv
// Self-checking bench for monitor_sumador4: directed scenarios followed by
// randomized traffic, all checked against an arithmetic model of the adder
// and of the checker's statistics. Two instances (CNT_W=8 and CNT_W=3) share
// the same stimulus so saturation is exercised on the narrow one.
module tb_monitor_sumador4;

    logic       CLK;
    logic       RST_N;
    logic       ENB;
    logic       RCI;
    logic [1:0] MODO;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q_DUT;
    logic       CLR_STATS;

    logic [3:0] exp8, exp3;
    logic       valid8, valid3, err8, err3, sticky8, sticky3;
    logic [7:0] errc8, chkc8;
    logic [2:0] errc3, chkc3;

    int n_total = 0;
    int n_pass  = 0;

    // model state
    int m_exp    = 0;
    bit m_valid  = 0;
    bit m_err    = 0;
    bit m_sticky = 0;
    int m_errc   = 0;
    int m_chkc   = 0;

    monitor_sumador4 #(.CNT_W(8)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .RCI(RCI), .MODO(MODO),
        .A(A), .B(B), .Q_DUT(Q_DUT), .CLR_STATS(CLR_STATS),
        .EXP(exp8), .VALID(valid8), .ERR(err8), .ERR_STICKY(sticky8),
        .ERR_CNT(errc8), .CHK_CNT(chkc8)
    );

    monitor_sumador4 #(.CNT_W(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .ENB(ENB), .RCI(RCI), .MODO(MODO),
        .A(A), .B(B), .Q_DUT(Q_DUT), .CLR_STATS(CLR_STATS),
        .EXP(exp3), .VALID(valid3), .ERR(err3), .ERR_STICKY(sticky3),
        .ERR_CNT(errc3), .CHK_CNT(chkc3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        if (obs !== req) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Compare both instances against the model.
    task automatic check_all(input string tag);
        check_val({tag, ".exp8"},    32'(exp8),    32'(m_exp));
        check_val({tag, ".valid8"},  32'(valid8),  32'(m_valid));
        check_val({tag, ".err8"},    32'(err8),    32'(m_err));
        check_val({tag, ".sticky8"}, 32'(sticky8), 32'(m_sticky));
        check_val({tag, ".errc8"},   32'(errc8),   32'(sat(m_errc, 8)));
        check_val({tag, ".chkc8"},   32'(chkc8),   32'(sat(m_chkc, 8)));
        check_val({tag, ".exp3"},    32'(exp3),    32'(m_exp));
        check_val({tag, ".valid3"},  32'(valid3),  32'(m_valid));
        check_val({tag, ".err3"},    32'(err3),    32'(m_err));
        check_val({tag, ".sticky3"}, 32'(sticky3), 32'(m_sticky));
        check_val({tag, ".errc3"},   32'(errc3),   32'(sat(m_errc, 3)));
        check_val({tag, ".chkc3"},   32'(chkc3),   32'(sat(m_chkc, 3)));
    endtask

    task automatic model_reset();
        m_exp = 0; m_valid = 0; m_err = 0; m_sticky = 0; m_errc = 0; m_chkc = 0;
    endtask

    // One clock: advance the model from the current inputs, take the edge,
    // check, then present the adder's correct Q (unknown until tracking).
    task automatic tick(input string tag);
        bit mis;
        int n_exp;
        mis   = m_valid && (Q_DUT !== 4'(m_exp));
        n_exp = m_exp;
        if (ENB) begin
            case (MODO)
                2'd1:    n_exp = (int'(A) + int'(B) + int'(RCI)) % 16;
                2'd2:    n_exp = (int'(A) - int'(B) + 16) % 16;
                2'd3:    n_exp = 0;
                default: n_exp = m_exp;
            endcase
        end
        m_err = mis;
        if (CLR_STATS) begin
            m_sticky = 0; m_errc = 0; m_chkc = 0;
        end else begin
            if (m_valid) m_chkc++;
            if (mis) begin
                m_errc++;
                m_sticky = 1;
            end
        end
        if (!m_valid && ENB && MODO != 2'd0) m_valid = 1;
        m_exp = n_exp;
        @(posedge CLK);
        #1;
        check_all(tag);
        if (m_valid) Q_DUT = 4'(m_exp);
        else         Q_DUT = 4'bxxxx;
    endtask

    initial begin
        RST_N = 1'b0; ENB = 1'b0; RCI = 1'b0; MODO = 2'd0;
        A = 4'd0; B = 4'd0; Q_DUT = 4'bxxxx; CLR_STATS = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset");
        RST_N = 1'b1;

        // bring-up: hold mode never starts tracking
        ENB = 1'b1; MODO = 2'd0;
        for (int i = 0; i < 4; i++) tick("bringup");
        check_val("bringup.valid", 32'(valid8), 32'd0);
        check_val("bringup.chk",   32'(chkc8),  32'd0);

        // add with carry-in: 9+8+1 = 18 -> 2
        MODO = 2'd1; RCI = 1'b1; A = 4'd9; B = 4'd8;
        tick("add");
        check_val("add.exp",   32'(exp8),   32'd2);
        check_val("add.valid", 32'(valid8), 32'd1);
        MODO = 2'd0;
        tick("add_cmp");
        check_val("add_cmp.err", 32'(err8),  32'd0);
        check_val("add_cmp.chk", 32'(chkc8), 32'd1);

        // subtract wrap, clear, disabled hold
        MODO = 2'd2; A = 4'd3; B = 4'd5;
        tick("sub");
        check_val("sub.exp", 32'(exp8), 32'd14);
        MODO = 2'd3;
        tick("clr");
        check_val("clr.exp", 32'(exp8), 32'd0);
        ENB = 1'b0; A = 4'd15; B = 4'd15;
        tick("hold");
        check_val("hold.exp", 32'(exp8), 32'd0);

        // injected fault after a correct add giving 7
        ENB = 1'b1; MODO = 2'd1; RCI = 1'b0; A = 4'd3; B = 4'd4;
        tick("add7");
        check_val("add7.exp", 32'(exp8), 32'd7);
        ENB = 1'b0;
        Q_DUT = 4'd6;
        tick("fault");
        check_val("fault.err",    32'(err8),    32'd1);
        check_val("fault.errc",   32'(errc8),   32'd1);
        check_val("fault.sticky", 32'(sticky8), 32'd1);
        tick("fault_after");
        check_val("fault_after.err",    32'(err8),    32'd0);
        check_val("fault_after.sticky", 32'(sticky8), 32'd1);

        // clear colliding with a mismatch
        CLR_STATS = 1'b1;
        Q_DUT = 4'd5;
        tick("collide");
        CLR_STATS = 1'b0;
        check_val("collide.err",    32'(err8),    32'd1);
        check_val("collide.errc",   32'(errc8),   32'd0);
        check_val("collide.chk",    32'(chkc8),   32'd0);
        check_val("collide.sticky", 32'(sticky8), 32'd0);

        // saturation on the narrow counters
        for (int i = 0; i < 9; i++) begin
            Q_DUT = 4'(m_exp) ^ 4'd1;
            tick("satur");
        end
        check_val("satur.errc3", 32'(errc3), 32'd7);
        check_val("satur.errc8", 32'(errc8), 32'd9);
        check_val("satur.err3",  32'(err3),  32'd1);

        // asynchronous reset between edges
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_val("async_rst.valid", 32'(valid8), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        Q_DUT = 4'bxxxx;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ENB       = ($urandom_range(0, 3) != 0);
            RCI       = 1'($urandom);
            MODO      = 2'($urandom);
            A         = 4'($urandom);
            B         = 4'($urandom);
            CLR_STATS = ($urandom_range(0, 15) == 0);
            if (m_valid && $urandom_range(0, 7) == 0)
                Q_DUT = 4'(m_exp) ^ 4'($urandom_range(1, 15));
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
